fetch_queue: RTL and testbench

Parametrised instruction-fetch front end with an instruction prefetch queue. It drives the instruction bus with single-outstanding, hold-until-done requests and buffers fetched instructions with their PCs in a DEPTH-entry FIFO. It presents them to the decode stage through a valid/ready handshake. A redirect from the branch/hazard logic flushes the queue and restarts fetch; an in-flight bus response is correctly discarded.

---
 rtl/fetch_queue.sv | 138 +++++++++++++
 tb/tb_fetch_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with DEPTH-entry prefetch queue
// Optional FETCH_BYPASS_EN: zero-latency bypass of an empty queue straight to decode.
module fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               ireq_valid,
  output logic [ADDR_W-1:0]  ireq_addr,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  req_addr;
  logic [ADDR_W-1:0]  pending_pc;
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [CW-1:0]      count;

  logic              fifo_valid;
  logic              bypass;
  logic              push;
  logic              pop;
  logic [CW:0]       cnt_after;
  logic [ADDR_W-1:0] redirect_aligned;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign fifo_valid       = (count != '0);
  assign pop              = fifo_valid & out_ready;

`ifdef FETCH_BYPASS_EN
  assign bypass    = !fifo_valid && (state == BUSY) && iresp_data_ok && !redirect && out_ready;
  assign out_valid = fifo_valid | bypass;
  assign out_pc    = fifo_valid ? pc_mem[head]    : (bypass ? req_addr   : '0);
  assign out_instr = fifo_valid ? instr_mem[head] : (bypass ? iresp_data : '0);
`else
  assign bypass    = 1'b0;
  assign out_valid = fifo_valid;
  assign out_pc    = fifo_valid ? pc_mem[head]    : '0;
  assign out_instr = fifo_valid ? instr_mem[head] : '0;
`endif

  // A bypassed response goes straight to decode and never occupies a slot.
  assign push      = (state == BUSY) && iresp_data_ok && !redirect && !bypass;
  assign cnt_after = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

  assign ireq_valid = (state != IDLE);
  assign ireq_addr  = req_addr;
  assign occupancy  = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= cnt_after[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= req_addr;
      instr_mem[tail] <= iresp_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_addr   <= RESET_PC;
      pending_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            req_addr <= redirect_aligned;
            state    <= BUSY;
          end else if (count < DEPTH_C) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (iresp_data_ok) begin
            if (redirect) begin
              req_addr <= redirect_aligned;
            end else begin
              req_addr <= req_addr + ADDR_W'(4);
              if (cnt_after >= DEPTH_X) state <= IDLE;
            end
          end else if (redirect) begin
            // The bus request cannot be withdrawn; wait for it and drop its data.
            pending_pc <= redirect_aligned;
            state      <= DISCARD;
          end
        end
        DISCARD: begin
          if (iresp_data_ok) begin
            req_addr <= redirect ? redirect_aligned : pending_pc;
            state    <= BUSY;
          end else if (redirect) begin
            pending_pc <= redirect_aligned;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Bus returns the bitwise complement of the low address word as the instruction.
  assign iresp_data = ~ireq_addr[31:0];

  fetch_queue #(.DEPTH(4), .ADDR_W(64), .INSTR_W(32), .RESET_PC(BASE)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [63:0] pc);
    logic [31:0] lo;
    lo = pc[31:0];
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, {32'd0, out_instr}, {32'd0, ~lo});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ireq_valid"}, {63'd0, ireq_valid}, 64'd0);
    chk({tag, "_ireq_addr"}, ireq_addr, BASE);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_out_pc"}, out_pc, 64'd0);
    chk({tag, "_out_instr"}, {32'd0, out_instr}, 64'd0);
    chk({tag, "_occ"}, {61'd0, occupancy}, 64'd0);
  endtask

  task automatic restart();
    reset         = 1'b0;
    iresp_data_ok = 1'b0;
    out_ready     = 1'b0;
    redirect      = 1'b0;
    #2;
    reset = 1'b1;
    step();
    chk("restart_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("restart_ireq_addr", ireq_addr, BASE);
  endtask

  initial begin
    logic [63:0] exp_pc;
    logic        will_pop;
    int          pops;
    int          cyc;

    reset         = 1'b0;
    iresp_data_ok = 1'b0;
    out_ready     = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;

    #12;
    check_reset_outputs("por");
    reset = 1'b1;
    step();
    chk("first_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("first_ireq_addr", ireq_addr, BASE);

    // Streaming: one instruction per cycle, queue never above one entry.
    iresp_data_ok = 1'b1;
    out_ready     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_out("stream", BASE + 64'(4 * i));
      chk("stream_addr", ireq_addr, BASE + 64'(4 * (i + 1)));
      chk("stream_occ", {61'd0, occupancy}, 64'd1);
    end

    // Fill to DEPTH with decode stalled, then release one slot.
    restart();
    iresp_data_ok = 1'b1;
    out_ready     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_occ", {61'd0, occupancy}, 64'(i + 1));
    end
    chk("full_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check_out("full_head", BASE);
    iresp_data_ok = 1'b0;
    step();
    chk("full_hold_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("full_hold_occ", {61'd0, occupancy}, 64'd4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_occ", {61'd0, occupancy}, 64'd3);
    check_out("pop_head", BASE + 64'h4);
    step();
    chk("refetch_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("refetch_ireq_addr", ireq_addr, BASE + 64'h10);

    // Redirect while the 0x08 request is outstanding.
    restart();
    iresp_data_ok = 1'b1;
    out_ready     = 1'b1;
    step();
    step();
    iresp_data_ok = 1'b0;
    redirect      = 1'b1;
    redirect_pc   = 64'h8000_1000;
    step();
    redirect = 1'b0;
    chk("disc_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("disc_ireq_addr", ireq_addr, BASE + 64'h8);
    chk("disc_out_valid", {63'd0, out_valid}, 64'd0);
    chk("disc_occ", {61'd0, occupancy}, 64'd0);
    iresp_data_ok = 1'b1;
    step();
    chk("disc_drop_addr", ireq_addr, 64'h8000_1000);
    chk("disc_drop_out_valid", {63'd0, out_valid}, 64'd0);
    step();
    check_out("disc_first", 64'h8000_1000);
    chk("disc_next_addr", ireq_addr, 64'h8000_1004);

    // Redirect coinciding with data_ok and pop, two entries queued.
    out_ready = 1'b0;
    step();
    chk("two_occ", {61'd0, occupancy}, 64'd2);
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_3000;
    step();
    redirect = 1'b0;
    chk("rd_occ", {61'd0, occupancy}, 64'd0);
    chk("rd_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rd_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("rd_ireq_addr", ireq_addr, 64'h8000_3000);
    step();
    check_out("rd_first", 64'h8000_3000);

    // Misaligned redirect target, then wrap with random decode stalls.
    out_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_2003;
    step();
    redirect = 1'b0;
    chk("align_addr", ireq_addr, 64'h8000_2000);
    chk("align_occ", {61'd0, occupancy}, 64'd0);
    exp_pc = 64'h8000_2000;
    pops   = 0;
    cyc    = 0;
    while (pops < 12 && cyc < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      #0;
      will_pop = out_valid && out_ready;
      step();
      cyc++;
      if (will_pop) begin
        pops++;
        exp_pc = exp_pc + 64'h4;
      end
      if (out_valid) check_out("wrap", exp_pc);
    end
    chk("wrap_pops", 64'(pops), 64'd12);

    // Asynchronous reset with a request outstanding and three entries queued.
    restart();
    iresp_data_ok = 1'b1;
    out_ready     = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_occ", {61'd0, occupancy}, 64'd3);
    chk("pre_rst_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("pre_rst_ireq_addr", ireq_addr, BASE + 64'hC);
    iresp_data_ok = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #2;
    reset = 1'b1;
    step();
    chk("post_rst_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("post_rst_ireq_addr", ireq_addr, BASE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
